// File: rtl/spi_master.sv
// spi_master: single-frame SPI mode-0 initiator sending {ctrl_tx, wdata} MSB first and capturing miso.
module spi_master #(
    parameter int CLK_DIV   = 4,
    parameter int CTRL_BITS = 8,
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CTRL_BITS-1:0] ctrl_tx,
    input  logic [DATA_BITS-1:0] wdata,
    output logic                 busy,
    output logic                 done,
    output logic [CTRL_BITS-1:0] ctrl_rx,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 sck,
    output logic                 mosi,
    output logic                 ncs,
    input  logic                 miso
);
    localparam int NB = CTRL_BITS + DATA_BITS;
    localparam int BW = $clog2(NB + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;
    state_t         state;
    logic [7:0]     hcnt;
    logic [BW-1:0]  bcnt;
    logic [NB-2:0]  tx;
    logic [NB-1:0]  rx;
    logic           half_end;
    assign half_end = hcnt == 8'(CLK_DIV - 1);
    // tx holds only the bits not yet on mosi; the frame MSB goes straight to mosi at acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            hcnt    <= '0;
            bcnt    <= '0;
            tx      <= '0;
            rx      <= '0;
            ncs     <= 1'b1;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ctrl_rx <= '0;
            rdata   <= '0;
        end else begin
            done <= 1'b0;
            hcnt <= half_end ? 8'd0 : hcnt + 8'd1;
            case (state)
                IDLE: begin
                    hcnt <= '0;
                    if (start) begin
                        state <= SHIFT;
                        tx    <= {ctrl_tx[CTRL_BITS-2:0], wdata};
                        rx    <= '0;
                        bcnt  <= '0;
                        mosi  <= ctrl_tx[CTRL_BITS-1];
                        ncs   <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: if (half_end) begin
                    sck <= !sck;
                    // end of high half: sample miso, present next bit as sck falls
                    if (sck) begin
                        rx   <= {rx[NB-2:0], miso};
                        tx   <= {tx[NB-3:0], 1'b0};
                        mosi <= tx[NB-2];
                        bcnt <= bcnt + 1'b1;
                        if (bcnt == BW'(NB - 1)) begin
                            state <= HOLD;
                            mosi  <= 1'b0;
                        end
                    end
                end
                HOLD: if (half_end) begin
                    state <= GAP;
                    ncs   <= 1'b1;
                end
                GAP: if (half_end) begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    ctrl_rx <= rx[NB-1:DATA_BITS];
                    rdata   <= rx[DATA_BITS-1:0];
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
